// File: rtl/icache_fetch.sv
// icache_fetch: direct-mapped, one-word-per-line instruction cache sitting
// between the fetch unit (IF) and the memory controller's IF read port.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   rdy               global ready; low freezes every register except done
//   clr               pipeline flush; kills the pending IF request
//   if_to_ic_*        IF request (level enable + word-aligned PC)
//   ic_to_if_*        one-cycle done pulse + fetched instruction
//   ic_to_mc_*        memory read request (level enable + word address)
//   mc_to_ic_*        memory read completion pulse + data
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | ready to look up the IF request; hits are answered here
// ST_MISS   | read outstanding at the memory controller, waiting for data
module icache_fetch #(
   parameter int IDX_BITS = 8,
   parameter int TAG_BITS = 32 - IDX_BITS - 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        clr,
   input  logic        if_to_ic_enable,
   input  logic [31:0] if_to_ic_pc,
   output logic        ic_to_if_done,
   output logic [31:0] ic_to_if_inst,
   output logic        ic_to_mc_enable,
   output logic [31:0] ic_to_mc_pc,
   input  logic        mc_to_ic_done,
   input  logic [31:0] mc_to_ic_result
);

   localparam int LINES = 1 << IDX_BITS;
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_MISS = 1'b1;

   logic [0:0]          state_q, state_d;
   logic                kill_q, kill_d;
   logic [29:0]         miss_wa_q, miss_wa_d;   // word address of the miss
   logic                done_q, done_d;
   logic [31:0]         inst_q, inst_d;
   logic                mc_en_q, mc_en_d;
   logic [31:0]         mc_pc_q, mc_pc_d;
   logic [LINES-1:0]    valid_q, valid_d;

   logic [TAG_BITS-1:0] tag_mem  [LINES];
   logic [31:0]         data_mem [LINES];

   logic [IDX_BITS-1:0] req_idx, fill_idx;
   logic [TAG_BITS-1:0] req_tag, fill_tag;
   logic                hit, fill_en, killed;
   logic                unused_pc_lsb;

   assign req_idx  = if_to_ic_pc[IDX_BITS+1:2];
   assign req_tag  = if_to_ic_pc[31:IDX_BITS+2];
   assign fill_idx = miss_wa_q[IDX_BITS-1:0];
   assign fill_tag = miss_wa_q[29:IDX_BITS];
   assign hit      = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
   assign fill_en  = (state_q == ST_MISS) && mc_to_ic_done;
   // A flush on the very cycle the data arrives still kills the response.
   assign killed   = kill_q | clr;
   assign unused_pc_lsb = ^if_to_ic_pc[1:0];

   always_comb begin
      state_d   = state_q;
      kill_d    = kill_q;
      miss_wa_d = miss_wa_q;
      done_d    = 1'b0;
      inst_d    = inst_q;
      mc_en_d   = mc_en_q;
      mc_pc_d   = mc_pc_q;
      valid_d   = valid_q;
      case (state_q)
         ST_IDLE: begin
            // done_q blocks re-serving a request IF is still holding high.
            if (if_to_ic_enable && !clr && !done_q) begin
               if (hit) begin
                  done_d = 1'b1;
                  inst_d = data_mem[req_idx];
               end else begin
                  mc_en_d   = 1'b1;
                  mc_pc_d   = {if_to_ic_pc[31:2], 2'b00};
                  miss_wa_d = if_to_ic_pc[31:2];
                  kill_d    = 1'b0;
                  state_d   = ST_MISS;
               end
            end
         end
         ST_MISS: begin
            // The controller finishes an in-flight read regardless of clr,
            // so enable stays up until its done and the word is still kept.
            kill_d = killed;
            if (mc_to_ic_done) begin
               valid_d[fill_idx] = 1'b1;
               mc_en_d           = 1'b0;
               state_d           = ST_IDLE;
               if (!killed) begin
                  done_d = 1'b1;
                  inst_d = mc_to_ic_result;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         kill_q    <= 1'b0;
         miss_wa_q <= '0;
         done_q    <= 1'b0;
         inst_q    <= '0;
         mc_en_q   <= 1'b0;
         mc_pc_q   <= '0;
         valid_q   <= '0;
      end else if (!rdy) begin
         done_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         kill_q    <= kill_d;
         miss_wa_q <= miss_wa_d;
         done_q    <= done_d;
         inst_q    <= inst_d;
         mc_en_q   <= mc_en_d;
         mc_pc_q   <= mc_pc_d;
         valid_q   <= valid_d;
      end
   end

   // Tag/data arrays carry no reset; the valid bits guard them.
   always_ff @(posedge clk) begin
      if (!rst && rdy && fill_en) begin
         tag_mem[fill_idx]  <= fill_tag;
         data_mem[fill_idx] <= mc_to_ic_result;
      end
   end

   assign ic_to_if_done   = done_q;
   assign ic_to_if_inst   = inst_q;
   assign ic_to_mc_enable = mc_en_q;
   assign ic_to_mc_pc     = mc_pc_q;

endmodule

// File: tb/tb_icache_fetch.sv
// tb_icache_fetch: directed bench for icache_fetch with a reactive memory
// controller and a transaction-level cache model checked every cycle.
module tb_icache_fetch;

   localparam int MC_LAT = 5;

   logic        clk = 1'b0;
   logic        rst, rdy, clr, if_en;
   logic [31:0] if_pc;
   logic        ic_to_if_done, ic_to_mc_enable;
   logic [31:0] ic_to_if_inst, ic_to_mc_pc;
   logic        mc_done = 1'b0;
   logic [31:0] mc_result = '0;

   int          n_checks = 0;
   int          n_fail = 0;

   // memory controller model state
   int          mc_cnt = 0;
   bit          spur = 0;
   bit          mc_seen = 0;
   logic [31:0] last_mc_pc = '0;

   // cache model: line index -> stored word address / data
   logic [31:0] m_addr [int];
   logic [31:0] m_data [int];
   bit          primed = 0;
   bit          pend = 0, killed = 0, served_last;
   logic [31:0] pend_pc;
   logic        exp_done, exp_mc_en;
   logic [31:0] exp_inst, exp_mc_pc;
   int          idx;

   icache_fetch dut (
      .clk             (clk),
      .rst             (rst),
      .rdy             (rdy),
      .clr             (clr),
      .if_to_ic_enable (if_en),
      .if_to_ic_pc     (if_pc),
      .ic_to_if_done   (ic_to_if_done),
      .ic_to_if_inst   (ic_to_if_inst),
      .ic_to_mc_enable (ic_to_mc_enable),
      .ic_to_mc_pc     (ic_to_mc_pc),
      .mc_to_ic_done   (mc_done),
      .mc_to_ic_result (mc_result)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      case (a)
         32'h0000_0000: return 32'h0000_0513;
         32'h0000_0004: return 32'h1111_1111;
         32'h0000_0404: return 32'h2222_2222;
         32'h0000_0100: return 32'h3333_3333;
         default:       return a ^ 32'hDEAD_0000;
      endcase
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      n_checks++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", nm, act, want, $time);
      end
   endtask

   // Negedge: compare DUT against model, advance memory controller, then
   // advance the model using the inputs the next posedge will see.
   initial begin
      forever begin
         @(negedge clk);
         if (primed) begin
            chk("done", {31'b0, ic_to_if_done}, {31'b0, exp_done});
            chk("inst", ic_to_if_inst, exp_inst);
            chk("mc_en", {31'b0, ic_to_mc_enable}, {31'b0, exp_mc_en});
            chk("mc_pc", ic_to_mc_pc, exp_mc_pc);
         end
         if (ic_to_mc_enable) begin
            mc_seen    = 1;
            last_mc_pc = ic_to_mc_pc;
         end

         if (rst || !rdy) begin
            mc_done = 0; mc_cnt = 0;
         end else if (mc_done) begin
            mc_done = 0; mc_cnt = 0;
         end else if (ic_to_mc_enable) begin
            mc_cnt++;
            if (mc_cnt >= MC_LAT) begin
               mc_done   = 1;
               mc_result = mem_rd(ic_to_mc_pc);
            end
         end else if (spur) begin
            mc_done   = 1;
            mc_result = 32'hBAD0_0BAD;
            spur      = 0;
         end

         if (rst) begin
            m_addr.delete(); m_data.delete();
            exp_done = 0; exp_inst = '0; exp_mc_en = 0; exp_mc_pc = '0;
            pend = 0; killed = 0; primed = 1;
         end else if (!rdy) begin
            exp_done = 0;
         end else begin
            served_last = exp_done;
            exp_done    = 0;
            if (pend) begin
               if (clr) killed = 1;
               if (mc_done) begin
                  idx         = int'((pend_pc >> 2) & 32'hFF);
                  m_addr[idx] = pend_pc;
                  m_data[idx] = mc_result;
                  exp_mc_en   = 0;
                  pend        = 0;
                  if (!killed) begin
                     exp_done = 1;
                     exp_inst = mc_result;
                  end
               end
            end else if (if_en && !clr && !served_last) begin
               idx = int'((if_pc >> 2) & 32'hFF);
               if (m_addr.exists(idx) && (m_addr[idx] >> 10) == (if_pc >> 10)) begin
                  exp_done = 1;
                  exp_inst = m_data[idx];
               end else begin
                  pend      = 1;
                  killed    = 0;
                  pend_pc   = {if_pc[31:2], 2'b00};
                  exp_mc_en = 1;
                  exp_mc_pc = pend_pc;
               end
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clk); #1;
   endtask

   // mode: 0 = must hit (latency 1, no memory read), 1 = must miss, 2 = either
   task automatic fetch(input logic [31:0] pc, input logic [31:0] want,
                        input int mode, input string nm);
      int lat;
      bit got;
      lat = 0; got = 0; mc_seen = 0;
      if_en = 1; if_pc = pc;
      while (!got && lat < 60) begin
         cyc();
         lat++;
         if (ic_to_if_done) got = 1;
      end
      if_en = 0;
      chk({nm, "_done_seen"}, {31'b0, got}, 32'd1);
      chk({nm, "_inst"}, ic_to_if_inst, want);
      if (mode == 0) begin
         chk({nm, "_hit_latency"}, lat, 32'd1);
         chk({nm, "_no_mc_read"}, {31'b0, mc_seen}, 32'd0);
      end else if (mode == 1) begin
         chk({nm, "_mc_read"}, {31'b0, mc_seen}, 32'd1);
      end
      cyc();
   endtask

   task automatic wait_mc_en(input string nm);
      int n;
      n = 0;
      while (!ic_to_mc_enable && n < 20) begin
         cyc();
         n++;
      end
      chk({nm, "_mc_en_rise"}, {31'b0, ic_to_mc_enable}, 32'd1);
   endtask

   initial begin
      bit saw_done, lost_en;
      rst = 1; rdy = 1; clr = 0; if_en = 0; if_pc = '0;
      repeat (3) cyc();
      chk("rst_done", {31'b0, ic_to_if_done}, 32'd0);
      chk("rst_inst", ic_to_if_inst, 32'd0);
      chk("rst_mc_en", {31'b0, ic_to_mc_enable}, 32'd0);
      chk("rst_mc_pc", ic_to_mc_pc, 32'd0);
      rst = 0;
      cyc();

      fetch(32'h0, 32'h0000_0513, 1, "cold");
      chk("cold_mc_pc", last_mc_pc, 32'h0);
      fetch(32'h0, 32'h0000_0513, 0, "rehit");

      fetch(32'h4, 32'h1111_1111, 1, "fill4");
      fetch(32'h404, 32'h2222_2222, 1, "conflict");
      chk("conflict_mc_pc", last_mc_pc, 32'h404);
      fetch(32'h4, 32'h1111_1111, 1, "refetch4");

      // flush during miss, IF drops the request
      if_en = 1; if_pc = 32'h100;
      wait_mc_en("kill");
      cyc(); cyc();
      clr = 1; if_en = 0;
      cyc();
      clr = 0;
      saw_done = 0;
      for (int n = 0; n < 20 && ic_to_mc_enable; n++) begin
         cyc();
         if (ic_to_if_done) saw_done = 1;
      end
      chk("kill_no_done", {31'b0, saw_done}, 32'd0);
      chk("kill_mc_en_dropped", {31'b0, ic_to_mc_enable}, 32'd0);
      fetch(32'h100, 32'h3333_3333, 0, "kill_then_hit");

      // flush during miss, IF re-requests the same line while it is filling
      if_en = 1; if_pc = 32'h180;
      wait_mc_en("kill2");
      cyc();
      clr = 1; if_en = 0;
      cyc();
      clr = 0;
      fetch(32'h180, 32'hDEAD_0180, 2, "held_after_kill");

      // flush on a hit cycle
      if_en = 1; if_pc = 32'h0; clr = 1;
      cyc();
      chk("clr_hit_done", {31'b0, ic_to_if_done}, 32'd0);
      chk("clr_hit_mc_en", {31'b0, ic_to_mc_enable}, 32'd0);
      if_en = 0; clr = 0;
      cyc();

      // spurious memory completion while idle
      spur = 1;
      repeat (3) cyc();
      chk("spur_ignored", {31'b0, ic_to_if_done}, 32'd0);

      // rdy stall during miss
      if_en = 1; if_pc = 32'h200;
      wait_mc_en("stall");
      cyc();
      rdy = 0; saw_done = 0; lost_en = 0;
      repeat (3) begin
         cyc();
         if (!ic_to_mc_enable) lost_en = 1;
         if (ic_to_if_done) saw_done = 1;
      end
      chk("stall_mc_en_held", {31'b0, lost_en}, 32'd0);
      chk("stall_no_done", {31'b0, saw_done}, 32'd0);
      rdy = 1;
      fetch(32'h200, 32'hDEAD_0200, 2, "stall_resume");

      // reset in the middle of a miss
      if_en = 1; if_pc = 32'h300;
      wait_mc_en("rstmiss");
      rst = 1; if_en = 0;
      cyc();
      chk("rstmiss_done", {31'b0, ic_to_if_done}, 32'd0);
      chk("rstmiss_inst", ic_to_if_inst, 32'd0);
      chk("rstmiss_mc_en", {31'b0, ic_to_mc_enable}, 32'd0);
      chk("rstmiss_mc_pc", ic_to_mc_pc, 32'd0);
      rst = 0;
      cyc();
      fetch(32'h0, 32'h0000_0513, 1, "post_rst_miss");

      repeat (3) cyc();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/icache_fetch.md
Name: icache_fetch

Overview:
- Direct-mapped, one-word-per-line instruction cache between the fetch unit (IF) and the memory controller's IF port.
- On a hit, returns the 32-bit instruction for the requested PC one cycle after the request.
- On a miss, issues a word read on the memory controller's IF port, fills the line, then returns the word.
- Absorbs pipeline flushes (clr) without corrupting cache contents or the memory-controller handshake.

Parameters:
- IDX_BITS, 8, index width; number of lines = 2^IDX_BITS (256 lines, 1 KiB of data).
- TAG_BITS, 22, tag width = 32 - IDX_BITS - 2; stored tag is pc[31:IDX_BITS+2].

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- rdy  in  1  global ready; when low, block freezes.
- clr  in  1  flush (branch mispredict); kills any pending IF request.
- if_to_ic_enable  in  1  IF request valid; level, held until ic_to_if_done or clr.
- if_to_ic_pc  in  32  request PC; word aligned; stable while enable high.
- ic_to_if_done  out  1  one-cycle pulse: ic_to_if_inst valid.
- ic_to_if_inst  out  32  fetched instruction.
- ic_to_mc_enable  out  1  memory read request to the memory controller; level.
- ic_to_mc_pc  out  32  word address of the miss.
- mc_to_ic_done  in  1  memory controller read complete (one-cycle pulse).
- mc_to_ic_result  in  32  memory controller read data, little-endian word.

Behaviour:
- Storage: valid[2^IDX], tag[2^IDX], data[2^IDX]. idx = pc[IDX_BITS+1:2]; tag = pc[31:IDX_BITS+2]. pc[1:0] ignored.
- Reset (rst=1 at posedge):
  - all valid bits cleared; state=IDLE.
  - ic_to_if_done=0, ic_to_if_inst=0, ic_to_mc_enable=0, ic_to_mc_pc=0.
  - Overrides rdy and clr.
- rdy=0: no register changes except ic_to_if_done forced 0. ic_to_mc_enable holds its value, so the memory controller (which drops its own progress on !rdy) restarts the read when rdy returns.
- All outputs are registered. ic_to_if_done defaults to 0 each active cycle.
- State IDLE, request accepted when if_to_ic_enable=1, clr=0 and ic_to_if_done=0. The done==0 condition guarantees one bubble after each response so a held enable is not re-served.
  - Hit (valid && tag match): next edge sets ic_to_if_done=1 and ic_to_if_inst=data[idx]; stay IDLE. Latency 1 cycle; throughput 1 instruction / 2 cycles.
  - Miss: next edge sets ic_to_mc_enable=1, ic_to_mc_pc={pc[31:2],2'b00}, latches the request PC, state=MISS_WAIT, ic_to_if_done stays 0.
- State MISS_WAIT, waiting for mc_to_ic_done=1:
  - Write data/tag at the latched idx; set valid.
  - ic_to_mc_enable=0 on the same edge. The memory controller's post-transfer gap cycle ignores enable, so no duplicate read is issued.
  - If the request is not killed: ic_to_if_done=1, ic_to_if_inst=mc_to_ic_result, state=IDLE.
  - If killed: fill only, no done pulse, state=IDLE.
- clr:
  - In IDLE: the request in that cycle is not accepted and a done pulse is not generated on that edge.
  - In MISS_WAIT: sets a killed flag. ic_to_mc_enable stays high until mc done, because the memory controller completes an in-flight IF transfer regardless of clr. The arriving word still fills the cache.
  - Cache contents are never invalidated by clr.
- A new IF request arriving while in MISS_WAIT with the killed flag set waits in IF (level enable). It is accepted in IDLE on the cycle after fill, and hits if it targets the filled line.
- Lines are replaced unconditionally on fill (direct-mapped, no write path, no self-modifying code support).
- mc_to_ic_done while IDLE (spurious) is ignored.

Test Plan:
- Cold miss: reset, request pc=0x0000_0000, memory controller returns 0x0000_0513 after 5 cycles -> ic_to_mc_pc=0x0, enable high until done, then ic_to_if_done=1, inst=0x0000_0513 one cycle after mc done; a repeat request for 0x0 -> done 1 cycle after accept, ic_to_mc_enable never asserted.
- Conflict: fill 0x0000_0004 (data 0x1111_1111), then request 0x0000_0404 (same idx 1, different tag) -> miss, ic_to_mc_pc=0x404, line replaced; a re-request for 0x4 -> miss again.
- clr during miss: request 0x100 misses, assert clr for 1 cycle before mc done -> no ic_to_if_done pulse, ic_to_mc_enable held until mc done; a next request for 0x100 -> hit, inst equals the filled word.
- clr on hit cycle: request 0x0 (cached) with clr=1 same cycle -> no done pulse, no state change.
- rdy stall: during MISS_WAIT drop rdy for 3 cycles -> ic_to_mc_enable stays 1, no done; after rdy=1 the memory controller read restarts and completes with the correct inst.
- Reset mid-miss: rst asserted in MISS_WAIT -> all outputs 0 next edge, valid cleared; a prior-hit address -> now misses.
